// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter width for n nibbles: ceil(log2(n)), never below 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rca_4_bit.sv
// Existing 4-bit ripple-carry adder reused by the nibble-serial datapath.
module rca_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = 5'(a) + 5'(b) + 5'(c_in);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks the operands one nibble per clock through rca_4_bit,
// with a registered carry chaining successive nibbles.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned N  = WIDTH / NIBBLE;
    localparam int unsigned CW = clog2(N);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [NIBBLE-1:0] nib_sum;
    logic             nib_carry;
    logic             last_nib;
    logic             accept;
    logic             run;
    logic             busy_d;
    logic             done_d;

    rca_4_bit u_rca (
        .a     (a_q[NIBBLE-1:0]),
        .b     (b_q[NIBBLE-1:0]),
        .c_in  (carry_q),
        .sum   (nib_sum),
        .c_out (nib_carry)
    );

    assign last_nib = (cnt_q == CW'(N - 1));
    // New nibble enters at the top; after N shifts nibble 0 sits at the bottom.
    assign psum_nxt = WIDTH'({nib_sum, psum_q} >> NIBBLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control decode and next values of the registered status outputs
    always_comb begin
        accept = 1'b0;
        run    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE:    accept = start;
            RUN:     run    = 1'b1;
            default: ;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Working registers and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            psum_q  <= '0;
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (run) begin
            a_q     <= a_q >> NIBBLE;
            b_q     <= b_q >> NIBBLE;
            psum_q  <= psum_nxt;
            carry_q <= nib_carry;
            cnt_q   <= cnt_q + CW'(1);
            if (last_nib) begin
                sum   <= psum_nxt;
                c_out <= nib_carry;
            end
        end
    end

endmodule
